// File: rtl/cnn_kernel_weights_pingpong_buf_pkg.sv
// Shared types for the ping-pong kernel weight buffer.
// Read-sweep state encoding and legal RAM read latencies.
package cnn_kernel_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_e;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic bit rl_legal(input int rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction

endpackage

// File: rtl/cnn_kernel_weights_pingpong_buf_if.sv
// Weight load stream: valid/ready handshake with an end-of-bank marker.
// The producer drives the master side, the buffer sits on the slave side.
interface cnn_kernel_weights_pingpong_buf_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_load_valid;
  logic [DATA_WIDTH-1:0] i_load_data;
  logic                  i_load_last;
  logic                  o_load_ready;

  modport master (
    output i_load_valid, i_load_data, i_load_last,
    input  o_load_ready
  );

  modport slave (
    input  i_load_valid, i_load_data, i_load_last,
    output o_load_ready
  );
endinterface

// File: rtl/cnn_kernel_weights_pingpong_buf_ram.sv
// One weight bank: simple dual-port RAM with a RL-stage registered read.
// Array contents are never reset; only the read pipeline is.
module kernel_bank_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1152,
  parameter int AW    = 11,
  parameter int RL    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q   [RL];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '{default: '0};
    end else begin
      if (re) q[0] <= mem[raddr];
      for (int i = 1; i < RL; i++) q[i] <= q[i-1];
    end
  end

  assign rdata = q[RL-1];
endmodule

// File: rtl/cnn_kernel_weights_pingpong_buf.sv
// Double-buffered kernel weight store: one bank loads while the other
// is swept filter/channel/row/col and streamed out with index tags.
module cnn_kernel_weights_pingpong_buf
  import cnn_kernel_pkg::*;
#(
  parameter int DATA_WIDTH           = 32,
  parameter int BANK_DEPTH           = 1152,
  parameter int ADDR_WIDTH           = $clog2(BANK_DEPTH),
  parameter int KERNEL_FILTER_WIDTH  = 8,
  parameter int KERNEL_CHANNEL_WIDTH = 8,
  parameter int KERNEL_ROW_WIDTH     = 2,
  parameter int KERNEL_COL_WIDTH     = 2,
  parameter int READ_LATENCY         = 2
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  cnn_kernel_weights_pingpong_buf_if.slave load,
  input  logic                            i_start,
  input  logic [KERNEL_FILTER_WIDTH-1:0]  i_num_filters,
  input  logic [KERNEL_CHANNEL_WIDTH-1:0] i_num_channels,
  input  logic [KERNEL_ROW_WIDTH-1:0]     i_kernel_rows,
  input  logic [KERNEL_COL_WIDTH-1:0]     i_kernel_cols,
  output logic                            o_read_avail,
  output logic                            o_busy,
  output logic                            o_weight_valid,
  output logic [DATA_WIDTH-1:0]           o_weight_data,
  output logic [KERNEL_FILTER_WIDTH-1:0]  o_weight_filter,
  output logic [KERNEL_CHANNEL_WIDTH-1:0] o_weight_channel,
  output logic [KERNEL_ROW_WIDTH-1:0]     o_weight_row,
  output logic [KERNEL_COL_WIDTH-1:0]     o_weight_col,
  output logic                            o_weight_last,
  output logic                            o_load_overflow
);
  localparam int FW = KERNEL_FILTER_WIDTH;
  localparam int CW = KERNEL_CHANNEL_WIDTH;
  localparam int RW = KERNEL_ROW_WIDTH;
  localparam int KW = KERNEL_COL_WIDTH;
  // Out-of-range latencies fall back to the deepest legal pipeline.
  localparam int RL = rl_legal(READ_LATENCY) ? READ_LATENCY : RL_MAX;
  localparam int TW = 2 + FW + CW + RW + KW;

  rd_state_e             state;
  logic [1:0]            full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [ADDR_WIDTH:0]   wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            drain_cnt;
  logic [FW-1:0]         f_cnt, f_ext;
  logic [CW-1:0]         c_cnt, c_ext;
  logic [RW-1:0]         r_cnt, r_ext;
  logic [KW-1:0]         k_cnt, k_ext;
  logic [TW-1:0]         tag_q [RL];
  logic [DATA_WIDTH-1:0] bank_q [2];

  logic load_fire, at_depth, wr_en;
  logic issue, col_end, row_end, chan_end, sweep_end;
  logic drain_done;

  assign load.o_load_ready = !full[wr_bank];
  assign load_fire = load.i_load_valid && load.o_load_ready;
  assign at_depth  = wr_addr == (ADDR_WIDTH+1)'(BANK_DEPTH);
  assign wr_en     = load_fire && !at_depth;

  assign issue     = state == R_RUN;
  assign col_end   = k_cnt == k_ext;
  assign row_end   = r_cnt == r_ext;
  assign chan_end  = c_cnt == c_ext;
  assign sweep_end = col_end && row_end && chan_end && (f_cnt == f_ext);
  assign drain_done = (state == R_DRAIN) && (drain_cnt == 2'(RL-1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      full            <= '0;
      wr_bank         <= 1'b0;
      wr_addr         <= '0;
      o_load_overflow <= 1'b0;
    end else begin
      if (load_fire && load.i_load_last) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        wr_addr       <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + (ADDR_WIDTH+1)'(1);
      end
      if (load_fire && at_depth) o_load_overflow <= 1'b1;
      // A load never targets the draining bank, so these bits never collide.
      if (drain_done) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= R_IDLE;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      f_cnt <= '0; c_cnt <= '0; r_cnt <= '0; k_cnt <= '0;
      f_ext <= '0; c_ext <= '0; r_ext <= '0; k_ext <= '0;
    end else begin
      unique case (state)
        R_IDLE: begin
          if (i_start && full[rd_bank]) begin
            f_ext   <= i_num_filters;
            c_ext   <= i_num_channels;
            r_ext   <= i_kernel_rows;
            k_ext   <= i_kernel_cols;
            f_cnt   <= '0; c_cnt <= '0;
            r_cnt   <= '0; k_cnt <= '0;
            rd_addr <= '0;
            state   <= R_RUN;
          end
        end
        R_RUN: begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
          k_cnt   <= col_end ? '0 : k_cnt + KW'(1);
          if (col_end) begin
            r_cnt <= row_end ? '0 : r_cnt + RW'(1);
            if (row_end) begin
              c_cnt <= chan_end ? '0 : c_cnt + CW'(1);
              if (chan_end) f_cnt <= f_cnt + FW'(1);
            end
          end
          if (sweep_end) begin
            state     <= R_DRAIN;
            drain_cnt <= '0;
          end
        end
        R_DRAIN: begin
          if (drain_done) begin
            state   <= R_IDLE;
            rd_bank <= ~rd_bank;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  // Tags ride alongside the RAM read so they line up with its data.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      tag_q <= '{default: '0};
    end else begin
      tag_q[0] <= issue ?
        {1'b1, sweep_end, f_cnt, c_cnt, r_cnt, k_cnt} : '0;
      for (int i = 1; i < RL; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    kernel_bank_ram #(
      .DW(DATA_WIDTH), .DEPTH(BANK_DEPTH),
      .AW(ADDR_WIDTH), .RL(RL)
    ) u_ram (
      .clk   (i_clock),
      .rst_n (i_reset),
      .we    (wr_en && (wr_bank == 1'(b))),
      .waddr (wr_addr[ADDR_WIDTH-1:0]),
      .wdata (load.i_load_data),
      .re    (issue && (rd_bank == 1'(b))),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  assign {o_weight_valid, o_weight_last, o_weight_filter,
          o_weight_channel, o_weight_row, o_weight_col} = tag_q[RL-1];
  assign o_weight_data = bank_q[rd_bank];
  assign o_read_avail  = (state == R_IDLE) && full[rd_bank];
  assign o_busy        = state != R_IDLE;
endmodule

// File: tb/tb_cnn_kernel_weights_pingpong_buf.sv
// Scoreboard bench for the ping-pong weight buffer.
// Loads are mirrored into a bank model; sweeps push expected tagged words.
module tb_cnn_kernel_weights_pingpong_buf;
  localparam int DW = 32;
  localparam int DEPTH = 1152;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  f;
    logic [7:0]  c;
    logic [1:0]  r;
    logic [1:0]  k;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnn_kernel_weights_pingpong_buf_if #(.DATA_WIDTH(DW)) lif ();

  logic        i_start = 1'b0;
  logic [7:0]  i_num_filters = '0;
  logic [7:0]  i_num_channels = '0;
  logic [1:0]  i_kernel_rows = '0;
  logic [1:0]  i_kernel_cols = '0;
  logic        o_read_avail, o_busy, o_weight_valid, o_weight_last;
  logic [31:0] o_weight_data;
  logic [7:0]  o_weight_filter, o_weight_channel;
  logic [1:0]  o_weight_row, o_weight_col;
  logic        o_load_overflow;

  cnn_kernel_weights_pingpong_buf dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .load             (lif),
    .i_start          (i_start),
    .i_num_filters    (i_num_filters),
    .i_num_channels   (i_num_channels),
    .i_kernel_rows    (i_kernel_rows),
    .i_kernel_cols    (i_kernel_cols),
    .o_read_avail     (o_read_avail),
    .o_busy           (o_busy),
    .o_weight_valid   (o_weight_valid),
    .o_weight_data    (o_weight_data),
    .o_weight_filter  (o_weight_filter),
    .o_weight_channel (o_weight_channel),
    .o_weight_row     (o_weight_row),
    .o_weight_col     (o_weight_col),
    .o_weight_last    (o_weight_last),
    .o_load_overflow  (o_load_overflow)
  );

  int total = 0;
  int bad = 0;
  exp_t sbq[$];
  logic [31:0] bmem [2][DEPTH];
  int m_wr_bank = 0;
  int m_rd_bank = 0;
  int m_wr_addr = 0;

  always @(negedge clk) begin
    if (o_weight_valid) begin
      exp_t e, g;
      g = {o_weight_data, o_weight_filter, o_weight_channel,
           o_weight_row, o_weight_col, o_weight_last};
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=%h want=none", g);
      end else begin
        e = sbq.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL weight_out got=%h want=%h", g, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input int base, output int stalls);
    int w;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      lif.i_load_valid = 1'b1;
      lif.i_load_data  = 32'(base + i);
      lif.i_load_last  = (i == n - 1);
      w = 0;
      while (!lif.o_load_ready && w < 50) begin
        tick();
        w++;
      end
      stalls += w;
      if (!lif.o_load_ready) begin
        total++; bad++;
        $display("FAIL load_ready_timeout got=0 want=1");
      end
      if (m_wr_addr < DEPTH) begin
        bmem[m_wr_bank][m_wr_addr] = 32'(base + i);
        m_wr_addr++;
      end
      tick();
    end
    lif.i_load_valid = 1'b0;
    lif.i_load_last  = 1'b0;
    m_wr_bank ^= 1;
    m_wr_addr = 0;
  endtask

  task automatic start_sweep(input int nf, input int nc, input int nr, input int nk);
    exp_t e;
    int a = 0;
    i_start = 1'b1;
    i_num_filters = 8'(nf); i_num_channels = 8'(nc);
    i_kernel_rows = 2'(nr); i_kernel_cols = 2'(nk);
    for (int f = 0; f <= nf; f++)
      for (int c = 0; c <= nc; c++)
        for (int r = 0; r <= nr; r++)
          for (int k = 0; k <= nk; k++) begin
            e.d = bmem[m_rd_bank][a];
            e.f = 8'(f); e.c = 8'(c); e.r = 2'(r); e.k = 2'(k);
            e.last = (f == nf) && (c == nc) && (r == nr) && (k == nk);
            sbq.push_back(e);
            a++;
          end
    m_rd_bank ^= 1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sbq.size() != 0 || o_busy) begin
      bad++;
      $display("FAIL sweep_timeout got=%0d_left want=0", sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    lif.i_load_valid = 1'b0;
    lif.i_load_data  = '0;
    lif.i_load_last  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({o_weight_valid, o_weight_last, o_busy, o_read_avail, o_load_overflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {o_weight_valid, o_weight_last, o_busy, o_read_avail, o_load_overflow});
    end
    total++;
    if (lif.o_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", lif.o_load_ready);
    end
    total++;
    if ({o_weight_data, o_weight_filter, o_weight_channel, o_weight_row, o_weight_col} !== 52'd0) begin
      bad++;
      $display("FAIL reset_data_tags got=%h want=0",
               {o_weight_data, o_weight_filter, o_weight_channel, o_weight_row, o_weight_col});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int st;
    logic [2:0] lat;
    load_words(36, 0, st);
    @(negedge clk);
    total++;
    if ({lif.o_load_ready, o_read_avail} !== 2'b11) begin
      bad++;
      $display("FAIL basic_ready_avail got=%b want=11", {lif.o_load_ready, o_read_avail});
    end
    tick();
    start_sweep(0, 3, 2, 2);
    @(negedge clk); lat[2] = o_weight_valid;
    @(negedge clk); lat[1] = o_weight_valid;
    @(negedge clk); lat[0] = o_weight_valid;
    total++;
    if (lat !== 3'b001) begin
      bad++;
      $display("FAIL basic_latency got=%b want=001", lat);
    end
    wait_drain(100);
  endtask

  task automatic test_pingpong;
    int st = 0;
    int n = 0;
    load_words(36, 1000, st);
    start_sweep(0, 3, 2, 2);
    fork
      load_words(36, 2000, st);
      begin
        while (!o_weight_last && n < 100) begin
          @(negedge clk);
          n++;
        end
      end
    join
    total++;
    if (st !== 0 || !o_weight_last) begin
      bad++;
      $display("FAIL pingpong_load_stall got=%0d_last%b want=0_last1", st, o_weight_last);
    end
    tick();
    total++;
    if (o_read_avail !== 1'b1) begin
      bad++;
      $display("FAIL pingpong_avail got=%b want=1", o_read_avail);
    end
    start_sweep(0, 3, 2, 2);
    @(negedge clk);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL pingpong_restart got=%b want=1", o_busy);
    end
    wait_drain(100);
  endtask

  task automatic test_full_block;
    int st;
    int acc = 0;
    load_words(10, 3000, st);
    load_words(10, 4000, st);
    total++;
    if ({lif.o_load_ready, o_read_avail} !== 2'b01) begin
      bad++;
      $display("FAIL full_ready got=%b want=01", {lif.o_load_ready, o_read_avail});
    end
    lif.i_load_valid = 1'b1;
    lif.i_load_data  = 32'hDEAD_BEEF;
    lif.i_load_last  = 1'b1;
    repeat (5) begin
      acc += int'(lif.o_load_ready);
      tick();
    end
    lif.i_load_valid = 1'b0;
    lif.i_load_last  = 1'b0;
    total++;
    if (acc !== 0) begin
      bad++;
      $display("FAIL full_accepts got=%0d want=0", acc);
    end
    start_sweep(0, 4, 0, 1);
    wait_drain(100);
    total++;
    if (lif.o_load_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_freed got=%b want=1", lif.o_load_ready);
    end
    start_sweep(0, 4, 0, 1);
    wait_drain(100);
  endtask

  task automatic test_start_ignored;
    int st;
    int cnt = 0;
    i_start = 1'b1;
    i_num_filters = '0; i_num_channels = '0;
    i_kernel_rows = '0; i_kernel_cols = '0;
    tick();
    i_start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(o_weight_valid | o_busy);
    end
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("FAIL start_empty got=%0d want=0", cnt);
    end
    tick();
    load_words(8, 6000, st);
    start_sweep(0, 1, 1, 1);
    repeat (3) tick();
    i_start = 1'b1;
    i_kernel_cols = 2'd3;
    tick();
    i_start = 1'b0;
    wait_drain(100);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(o_weight_valid | o_busy);
    end
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("FAIL start_midsweep got=%0d want=0", cnt);
    end
    tick();
  endtask

  task automatic test_overflow;
    int st;
    total++;
    if (o_load_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_before got=%b want=0", o_load_overflow);
    end
    load_words(DEPTH + 1, 5000, st);
    total++;
    if ({o_load_overflow, o_read_avail} !== 2'b11) begin
      bad++;
      $display("FAIL ovf_set got=%b want=11", {o_load_overflow, o_read_avail});
    end
    start_sweep(71, 0, 3, 3);
    wait_drain(DEPTH + 50);
    total++;
    if (o_load_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", o_load_overflow);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int st;
    int v = 0;
    load_words(36, 7000, st);
    start_sweep(0, 3, 2, 2);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    sbq.delete();
    repeat (3) begin
      @(negedge clk);
      v += int'(o_weight_valid);
    end
    total++;
    if (v !== 0) begin
      bad++;
      $display("FAIL rst_flush got=%0d want=0", v);
    end
    tick();
    rst_n = 1'b1;
    m_wr_bank = 0; m_rd_bank = 0; m_wr_addr = 0;
    tick();
    @(negedge clk);
    total++;
    if ({o_read_avail, lif.o_load_ready, o_busy, o_load_overflow} !== 4'b0100) begin
      bad++;
      $display("FAIL rst_after got=%b want=0100",
               {o_read_avail, lif.o_load_ready, o_busy, o_load_overflow});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pingpong();
    test_full_block();
    test_start_ignored();
    test_overflow();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
